vend_channel_ctrl: RTL and testbench
====================================

VEND_CHANNEL_CTRL -- requirements
Module: vend_channel_ctrl

Interface
REQ-001 SHALL provide parameter NUM_ITEMS, default 16, the number of product channels (1..2**IDX_W).
REQ-002 SHALL provide parameter IDX_W, default 4, the channel index width.
REQ-003 SHALL provide parameter TIMEOUT, default 40, the IDLE cycles before an automatic cancel (1..2**CNT_W-1).
REQ-004 SHALL provide parameter CNT_W, default 8, the timeout counter width.
REQ-005 SHALL provide the following ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sel_valid  in  1  one-cycle selection strobe.
- sel_index  in  IDX_W  selected channel, sampled with sel_valid.
- cancel  in  1  user cancel level.
- stock  in  NUM_ITEMS  per-channel in-stock flags.
- disp_ack  in  1  dispenser acknowledge.
- cancel_ack  in  1  refund unit acknowledge.
- state  out  2  current state: IDLE=00, DISPENSE=01, CHECK=10, CANCEL=11.
- disp_req  out  1  dispense request.
- disp_index  out  IDX_W  latched channel, valid while disp_req=1.
- cancel_req  out  1  refund request.
- out_of_stock  out  1  one-cycle pulse.
- timed_out  out  1  one-cycle pulse.
- vend_count  out  16  completed vends, saturating.

Function
REQ-006 All outputs SHALL be registered; every state change SHALL take effect on a rising edge of clk.
REQ-007 In IDLE, sel_valid=1 with sel_index<NUM_ITEMS and cancel=0 SHALL latch sel_index into disp_index and move to CHECK on the next edge.
REQ-008 In IDLE, sel_valid=1 with sel_index>=NUM_ITEMS SHALL pulse out_of_stock for one cycle and remain in IDLE.
REQ-009 CHECK SHALL last exactly one cycle: stock[disp_index]=1 moves to DISPENSE with disp_req=1 on the same edge; otherwise out_of_stock pulses for one cycle and the state returns to IDLE.
REQ-010 Latency from a sel_valid edge N SHALL be disp_req=1 after edge N+2.
REQ-011 DISPENSE SHALL use a 4-phase handshake: disp_req held until disp_ack=1, then disp_req dropped; the state SHALL remain DISPENSE until disp_ack=0, then return to IDLE.
REQ-012 vend_count SHALL increment by 1 on the edge where disp_req falls, and SHALL saturate at 16'hFFFF.
REQ-013 cancel=1 in IDLE or CHECK SHALL move to CANCEL with cancel_req=1 on the next edge; cancel SHALL win over a simultaneous sel_valid or stock result.
REQ-014 cancel SHALL be ignored in DISPENSE and in CANCEL.
REQ-015 CANCEL SHALL use a 4-phase handshake on cancel_req/cancel_ack, then return to IDLE once cancel_ack=0.
REQ-016 disp_index SHALL hold its last value outside DISPENSE.
REQ-017 The timeout counter SHALL increment on each IDLE cycle without sel_valid.
REQ-018 The timeout counter SHALL clear on sel_valid and on every entry to IDLE.
REQ-019 When the timeout counter equals TIMEOUT in IDLE, the block SHALL move to CANCEL, pulse timed_out for one cycle, and assert cancel_req.
REQ-020 A timeout and cancel in the same cycle SHALL produce a single CANCEL entry, with timed_out=1.
REQ-021 An ack arriving while its request is low SHALL be ignored.

Reset
REQ-022 rst=0 SHALL immediately, without waiting for clk, force: state=IDLE, disp_req=0, cancel_req=0, out_of_stock=0, timed_out=0, disp_index=0, vend_count=0, timeout counter=0.
REQ-023 Reset mid-handshake SHALL abandon the transaction; no vend_count update SHALL occur.
REQ-024 Normal operation SHALL resume on the first rising edge after rst returns to 1.

Configuration
REQ-025 Macro VEND_TIMEOUT_EN defined SHALL include the timeout counter and timed_out behaviour as in REQ-017..REQ-020.
REQ-026 With VEND_TIMEOUT_EN undefined, the counter SHALL be omitted, timed_out SHALL be tied to 0, and IDLE SHALL wait indefinitely.

Verification
REQ-027 Bench SHALL cover:
- Normal vend: stock=16'h0008, sel_index=3 -> CHECK, then DISPENSE; disp_req=1 two edges after sel_valid; disp_index=3; ack sequence -> vend_count=1, then IDLE.
- Out of stock: stock=0, sel_index=5 -> out_of_stock one-cycle pulse; IDLE; disp_req never rises.
- Invalid index: NUM_ITEMS=10, sel_index=12 -> out_of_stock pulse; state stays 00.
- Timeout (VEND_TIMEOUT_EN, TIMEOUT=40): 40 idle cycles -> state=11, timed_out pulse, cancel_req=1; ack cycle -> IDLE; counter restarts at 0.
- Cancel vs sel_valid: both high in IDLE -> CANCEL, not CHECK.
- Cancel during DISPENSE: ignored.
- Reset mid-DISPENSE: rst=0 -> disp_req=0 asynchronously; vend_count unchanged-from-reset (0).

Source files
------------

// File: rtl/vend_channel_ctrl.sv
// Vending channel controller: selection check, dispense and refund 4-phase handshakes.
// Optional idle auto-cancel is compiled in when VEND_TIMEOUT_EN is defined.
module vend_channel_ctrl #(
    parameter int NUM_ITEMS = 16,
    parameter int IDX_W     = 4,
    parameter int TIMEOUT   = 40,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_index,
    input  logic                 cancel,
    input  logic [NUM_ITEMS-1:0] stock,
    input  logic                 disp_ack,
    input  logic                 cancel_ack,
    output logic [1:0]           state,
    output logic                 disp_req,
    output logic [IDX_W-1:0]     disp_index,
    output logic                 cancel_req,
    output logic                 out_of_stock,
    output logic                 timed_out,
    output logic [15:0]          vend_count
);

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] DISPENSE = 2'b01;
    localparam logic [1:0] CHECK    = 2'b10;
    localparam logic [1:0] CANCEL   = 2'b11;

    logic [1:0]       state_q, state_d;
    logic             dreq_q, dreq_d;
    logic             creq_q, creq_d;
    logic             oos_q, oos_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      vend_q, vend_d;
    logic             timeout_hit;
    logic             sel_in_range;
    logic [(2**IDX_W)-1:0] stock_pad;

    // Widen stock to the full index space so any latched index is a legal select.
    always_comb begin
        stock_pad = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_pad[i] = stock[i];
        end
    end

    assign sel_in_range = ({1'b0, sel_index} < (IDX_W+1)'(NUM_ITEMS));

    always_comb begin
        state_d = state_q;
        dreq_d  = dreq_q;
        creq_d  = creq_q;
        oos_d   = 1'b0;
        idx_d   = idx_q;
        vend_d  = vend_q;
        case (state_q)
            IDLE: begin
                if (timeout_hit || cancel) begin
                    state_d = CANCEL;
                    creq_d  = 1'b1;
                end else if (sel_valid) begin
                    if (sel_in_range) begin
                        idx_d   = sel_index;
                        state_d = CHECK;
                    end else begin
                        oos_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (cancel) begin
                    state_d = CANCEL;
                    creq_d  = 1'b1;
                end else if (stock_pad[idx_q]) begin
                    state_d = DISPENSE;
                    dreq_d  = 1'b1;
                end else begin
                    oos_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DISPENSE: begin
                if (dreq_q) begin
                    if (disp_ack) begin
                        dreq_d = 1'b0;
                        if (vend_q != 16'hFFFF) begin
                            vend_d = vend_q + 16'd1;
                        end
                    end
                end else if (!disp_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (creq_q) begin
                    if (cancel_ack) begin
                        creq_d = 1'b0;
                    end
                end else if (!cancel_ack) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dreq_q  <= 1'b0;
            creq_q  <= 1'b0;
            oos_q   <= 1'b0;
            idx_q   <= '0;
            vend_q  <= '0;
        end else begin
            state_q <= state_d;
            dreq_q  <= dreq_d;
            creq_q  <= creq_d;
            oos_q   <= oos_d;
            idx_q   <= idx_d;
            vend_q  <= vend_d;
        end
    end

`ifdef VEND_TIMEOUT_EN
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             to_q;

    assign timeout_hit = (tcnt_q == CNT_W'(TIMEOUT));

    // Counts only uninterrupted IDLE cycles; anything else restarts from zero.
    always_comb begin
        tcnt_d = '0;
        if (state_q == IDLE && state_d == IDLE && !sel_valid) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            to_q   <= (state_q == IDLE) && timeout_hit;
        end
    end

    assign timed_out = to_q;
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    assign state        = state_q;
    assign disp_req     = dreq_q;
    assign disp_index   = idx_q;
    assign cancel_req   = creq_q;
    assign out_of_stock = oos_q;
    assign vend_count   = vend_q;

endmodule

// File: tb/tb_vend_channel_ctrl.sv
// Self-checking bench for vend_channel_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the controller rules.
module tb_vend_channel_ctrl;

    localparam int NUM    = 10;
    localparam int IW     = 4;
    localparam int TO     = 40;
    localparam int CW     = 8;
`ifdef VEND_TIMEOUT_EN
    localparam bit TO_EN  = 1'b1;
`else
    localparam bit TO_EN  = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           sel_valid;
    logic [IW-1:0]  sel_index;
    logic           cancel;
    logic [NUM-1:0] stock;
    logic           disp_ack;
    logic           cancel_ack;
    logic [1:0]     state;
    logic           disp_req;
    logic [IW-1:0]  disp_index;
    logic           cancel_req;
    logic           out_of_stock;
    logic           timed_out;
    logic [15:0]    vend_count;

    int checks = 0;
    int errors = 0;

    // Model: phase is 0 idle, 1 dispensing, 2 checking, 3 refunding
    int m_phase, m_idx, m_vends, m_idle_run;
    bit m_dreq, m_creq, m_oos, m_to;

    vend_channel_ctrl #(.NUM_ITEMS(NUM), .IDX_W(IW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_index(sel_index),
        .cancel(cancel), .stock(stock), .disp_ack(disp_ack), .cancel_ack(cancel_ack),
        .state(state), .disp_req(disp_req), .disp_index(disp_index),
        .cancel_req(cancel_req), .out_of_stock(out_of_stock), .timed_out(timed_out),
        .vend_count(vend_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_vends = 0; m_idle_run = 0;
        m_dreq = 0; m_creq = 0; m_oos = 0; m_to = 0;
    endtask

    task automatic model_edge();
        int nxt;
        bit waiting;
        nxt = m_phase;
        m_oos = 0;
        m_to = 0;
        if (m_phase == 0) begin
            waiting = TO_EN && (m_idle_run == TO);
            if (waiting || cancel) begin
                nxt = 3; m_creq = 1; m_to = waiting;
            end else if (sel_valid) begin
                if (int'(sel_index) < NUM) begin
                    m_idx = int'(sel_index); nxt = 2;
                end else begin
                    m_oos = 1;
                end
            end
        end else if (m_phase == 2) begin
            if (cancel) begin
                nxt = 3; m_creq = 1;
            end else if (stock[m_idx]) begin
                nxt = 1; m_dreq = 1;
            end else begin
                nxt = 0; m_oos = 1;
            end
        end else if (m_phase == 1) begin
            if (m_dreq && disp_ack) begin
                m_dreq = 0;
                m_vends = (m_vends < 65535) ? m_vends + 1 : 65535;
            end else if (!m_dreq && !disp_ack) begin
                nxt = 0;
            end
        end else begin
            if (m_creq && cancel_ack) m_creq = 0;
            else if (!m_creq && !cancel_ack) nxt = 0;
        end
        m_idle_run = (m_phase == 0 && nxt == 0 && !sel_valid) ? m_idle_run + 1 : 0;
        m_phase = nxt;
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_phase));
        chk("disp_req", 32'(disp_req), 32'(m_dreq));
        chk("disp_index", 32'(disp_index), 32'(m_idx));
        chk("cancel_req", 32'(cancel_req), 32'(m_creq));
        chk("out_of_stock", 32'(out_of_stock), 32'(m_oos));
        chk("timed_out", 32'(timed_out), 32'(m_to));
        chk("vend_count", 32'(vend_count), 32'(m_vends));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0; sel_valid = 0; sel_index = '0; cancel = 0;
        stock = '0; disp_ack = 0; cancel_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b1;

        // Normal vend on channel 3
        stock = 10'h008; sel_valid = 1; sel_index = 4'd3;
        tick();
        chk("vend_to_check", 32'(state), 32'd2);
        sel_valid = 0;
        tick();
        chk("vend_req_n2", 32'(disp_req), 32'd1);
        chk("vend_index", 32'(disp_index), 32'd3);
        cancel = 1;
        tick();
        cancel = 0;
        chk("cancel_in_dispense", 32'(state), 32'd1);
        disp_ack = 1;
        tick();
        chk("vend_count_1", 32'(vend_count), 32'd1);
        chk("req_dropped", 32'(disp_req), 32'd0);
        tick();
        chk("hold_until_ack_low", 32'(state), 32'd1);
        disp_ack = 0;
        tick();
        chk("vend_back_idle", 32'(state), 32'd0);

        // Out of stock on channel 5
        stock = '0; sel_valid = 1; sel_index = 4'd5;
        tick();
        sel_valid = 0;
        tick();
        chk("oos_pulse", 32'(out_of_stock), 32'd1);
        chk("oos_idle", 32'(state), 32'd0);
        tick();
        chk("oos_one_cycle", 32'(out_of_stock), 32'd0);

        // Index beyond NUM_ITEMS
        sel_valid = 1; sel_index = 4'd12;
        tick();
        chk("bad_idx_oos", 32'(out_of_stock), 32'd1);
        chk("bad_idx_state", 32'(state), 32'd0);
        sel_valid = 0;
        tick();

        // Cancel beats a simultaneous selection
        stock = 10'h008; cancel = 1; sel_valid = 1; sel_index = 4'd3;
        tick();
        chk("cancel_wins", 32'(state), 32'd3);
        chk("cancel_req", 32'(cancel_req), 32'd1);
        cancel = 0; sel_valid = 0;
        tick();
        cancel_ack = 1;
        tick();
        cancel_ack = 0;
        tick();
        chk("cancel_done", 32'(state), 32'd0);

`ifdef VEND_TIMEOUT_EN
        repeat (TO) tick();
        chk("to_not_yet", 32'(state), 32'd0);
        tick();
        chk("to_state", 32'(state), 32'd3);
        chk("to_pulse", 32'(timed_out), 32'd1);
        chk("to_creq", 32'(cancel_req), 32'd1);
        tick();
        chk("to_one_cycle", 32'(timed_out), 32'd0);
        cancel_ack = 1;
        tick();
        cancel_ack = 0;
        tick();
        chk("to_back_idle", 32'(state), 32'd0);
        repeat (TO) tick();
        chk("to_restart_wait", 32'(state), 32'd0);
        tick();
        chk("to_restart_fire", 32'(state), 32'd3);
        cancel_ack = 1;
        tick();
        cancel_ack = 0;
        tick();
`else
        repeat (TO + 20) tick();
        chk("no_timeout_state", 32'(state), 32'd0);
        chk("no_timeout_pulse", 32'(timed_out), 32'd0);
`endif

        // Reset in the middle of a dispense
        stock = 10'h008; sel_valid = 1; sel_index = 4'd3;
        tick();
        sel_valid = 0;
        tick();
        chk("pre_reset_req", 32'(disp_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_req", 32'(disp_req), 32'd0);
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_vends", 32'(vend_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        for (int n = 0; n < 600; n++) begin
            sel_valid  = ($urandom_range(0, 4) == 0);
            sel_index  = IW'($urandom_range(0, 15));
            cancel     = ($urandom_range(0, 15) == 0);
            stock      = NUM'($urandom);
            disp_ack   = $urandom_range(0, 1) == 1;
            cancel_ack = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
